// File: rtl/issue_queue_pkg.sv
// Shared types and widths for the issue queue.
//   ROB_ADDR_WIDTH / DATA_WIDTH / OPGEN_WIDTH / ADDR_WIDTH : core bus widths
//   IQ_ENTRY_NUM / IQ_PAYLOAD_WIDTH : default queue depth and side-field width
//   iq_slot_t : architectural contents of one queue slot (payload kept separately
//               because its width is a module parameter)
//   slot_op_e : what a slot loads at the next edge
package issue_queue_pkg;

  localparam int ROB_ADDR_WIDTH   = 5;
  localparam int DATA_WIDTH       = 32;
  localparam int OPGEN_WIDTH      = 8;
  localparam int ADDR_WIDTH       = 32;
  localparam int IQ_ENTRY_NUM     = 4;
  localparam int IQ_PAYLOAD_WIDTH = 64;

  typedef struct packed {
    logic                      valid;
    logic [ROB_ADDR_WIDTH-1:0] rob_addr;
    logic [OPGEN_WIDTH-1:0]    opgen;
    logic                      is_ref_1;
    logic                      is_ref_2;
    logic [DATA_WIDTH-1:0]     data_1;
    logic [DATA_WIDTH-1:0]     data_2;
    logic [ADDR_WIDTH-1:0]     pc;
  } iq_slot_t;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,  // keep own contents
    SLOT_SHIFT = 2'd1,  // take the younger neighbour (collapse after issue)
    SLOT_LOAD  = 2'd2   // take the incoming instruction
  } slot_op_e;

  // An operand waiting on a tag is satisfied by a matching CDB broadcast.
  function automatic logic tag_hit(input logic                      is_ref,
                                   input logic [ROB_ADDR_WIDTH-1:0] stored_tag,
                                   input logic                      cdb_en,
                                   input logic [ROB_ADDR_WIDTH-1:0] cdb_tag);
    return is_ref && cdb_en && (stored_tag == cdb_tag);
  endfunction

endpackage

// File: rtl/issue_queue_entry.sv
// One issue-queue slot.
//   clk, rst, flush        : clock, synchronous resets (both clear the slot)
//   op                     : hold / shift-from-neighbour / load-new select
//   neighbour, neighbour_payload : contents of the next younger slot
//   load_slot, load_payload      : incoming instruction
//   cdb_en, cdb_rob_addr, cdb_data : result broadcast
//   slot, payload          : registered slot contents
// Wake-up is applied to whatever the mux selects, so a shifted entry keeps its
// wake-up, and an inserted operand matching the same-cycle broadcast is stored
// already resolved.
module issue_queue_entry
  import issue_queue_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = IQ_PAYLOAD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  slot_op_e                  op,
  input  iq_slot_t                  neighbour,
  input  logic [PAYLOAD_WIDTH-1:0]  neighbour_payload,
  input  iq_slot_t                  load_slot,
  input  logic [PAYLOAD_WIDTH-1:0]  load_payload,
  input  logic                      cdb_en,
  input  logic [ROB_ADDR_WIDTH-1:0] cdb_rob_addr,
  input  logic [DATA_WIDTH-1:0]     cdb_data,
  output iq_slot_t                  slot,
  output logic [PAYLOAD_WIDTH-1:0]  payload
);

  iq_slot_t                 src;
  iq_slot_t                 slot_next;
  logic [PAYLOAD_WIDTH-1:0] payload_next;

  always_comb begin
    src          = slot;
    payload_next = payload;
    case (op)
      SLOT_SHIFT: begin
        src          = neighbour;
        payload_next = neighbour_payload;
      end
      SLOT_LOAD: begin
        src          = load_slot;
        payload_next = load_payload;
      end
      default: begin
        src          = slot;
        payload_next = payload;
      end
    endcase

    slot_next = src;
    if (src.valid && tag_hit(src.is_ref_1, src.data_1[ROB_ADDR_WIDTH-1:0], cdb_en, cdb_rob_addr)) begin
      slot_next.data_1   = cdb_data;
      slot_next.is_ref_1 = 1'b0;
    end
    if (src.valid && tag_hit(src.is_ref_2, src.data_2[ROB_ADDR_WIDTH-1:0], cdb_en, cdb_rob_addr)) begin
      slot_next.data_2   = cdb_data;
      slot_next.is_ref_2 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slot    <= '0;
      payload <= '0;
    end else begin
      slot    <= slot_next;
      payload <= payload_next;
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Issue-stage reservation queue (collapsing, slot 0 oldest).
//   clk, rst, flush, stall_next_stage : clock, sync reset, pipeline flush, EX back-pressure
//   can_issue_in, rob_addr_in, opgen_in, operand_is_ref_*_in, operand_data_*_in,
//   pc_in, payload_in : incoming renamed instruction
//   full              : no free slot (upstream stall)
//   cdb_en, cdb_rob_addr, cdb_data : result broadcast for wake-up
//   issue_valid, issue_* : registered instruction toward EX
//
// Handshakes: an instruction is accepted on any edge where can_issue_in is high
// and full (registered) is low; otherwise it is dropped and upstream must hold it.
// issue_valid/issue_* change only on edges where stall_next_stage is low; while
// stall_next_stage is high they hold and nothing leaves the queue.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int ENTRY_NUM     = IQ_ENTRY_NUM,
  parameter int PAYLOAD_WIDTH = IQ_PAYLOAD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall_next_stage,
  input  logic                      can_issue_in,
  input  logic [ROB_ADDR_WIDTH-1:0] rob_addr_in,
  input  logic [OPGEN_WIDTH-1:0]    opgen_in,
  input  logic                      operand_is_ref_1_in,
  input  logic                      operand_is_ref_2_in,
  input  logic [DATA_WIDTH-1:0]     operand_data_1_in,
  input  logic [DATA_WIDTH-1:0]     operand_data_2_in,
  input  logic [ADDR_WIDTH-1:0]     pc_in,
  input  logic [PAYLOAD_WIDTH-1:0]  payload_in,
  output logic                      full,
  input  logic                      cdb_en,
  input  logic [ROB_ADDR_WIDTH-1:0] cdb_rob_addr,
  input  logic [DATA_WIDTH-1:0]     cdb_data,
  output logic                      issue_valid,
  output logic [ROB_ADDR_WIDTH-1:0] issue_rob_addr,
  output logic [OPGEN_WIDTH-1:0]    issue_opgen,
  output logic [DATA_WIDTH-1:0]     issue_operand_1,
  output logic [DATA_WIDTH-1:0]     issue_operand_2,
  output logic [ADDR_WIDTH-1:0]     issue_pc,
  output logic [PAYLOAD_WIDTH-1:0]  issue_payload
);

  localparam int CW = $clog2(ENTRY_NUM + 1);
  localparam int IW = $clog2(ENTRY_NUM);

  iq_slot_t                 slot_q  [ENTRY_NUM];
  logic [PAYLOAD_WIDTH-1:0] pay_q   [ENTRY_NUM];
  iq_slot_t                 nb_slot [ENTRY_NUM];
  logic [PAYLOAD_WIDTH-1:0] nb_pay  [ENTRY_NUM];
  slot_op_e                 slot_op [ENTRY_NUM];

  logic [ENTRY_NUM-1:0] ready;
  logic [IW-1:0]        sel;
  logic                 do_issue;
  logic                 do_insert;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        ins_pos;
  iq_slot_t             new_slot;

  assign full      = (count_q == CW'(ENTRY_NUM));
  assign do_insert = can_issue_in && !full;

  always_comb begin
    new_slot          = '0;
    new_slot.valid    = 1'b1;
    new_slot.rob_addr = rob_addr_in;
    new_slot.opgen    = opgen_in;
    new_slot.is_ref_1 = operand_is_ref_1_in;
    new_slot.is_ref_2 = operand_is_ref_2_in;
    new_slot.data_1   = operand_data_1_in;
    new_slot.data_2   = operand_data_2_in;
    new_slot.pc       = pc_in;
  end

  // Priority select: iterate from the top so the lowest ready index wins.
  always_comb begin
    sel = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      ready[i] = slot_q[i].valid && !slot_q[i].is_ref_1 && !slot_q[i].is_ref_2;
      if (ready[i]) sel = IW'(i);
    end
    do_issue = (|ready) && !stall_next_stage;
  end

  // With a same-cycle issue the queue collapses by one, so the new entry
  // lands one slot lower than the registered count.
  always_comb begin
    ins_pos = do_issue ? (count_q - CW'(1)) : count_q;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      slot_op[i] = SLOT_HOLD;
      if (do_insert && (int'(ins_pos) == i)) slot_op[i] = SLOT_LOAD;
      else if (do_issue && (i >= int'(sel))) slot_op[i] = SLOT_SHIFT;
    end
  end

  for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_slot
    if (g == ENTRY_NUM - 1) begin : g_top
      assign nb_slot[g] = '0;
      assign nb_pay[g]  = '0;
    end else begin : g_mid
      assign nb_slot[g] = slot_q[g+1];
      assign nb_pay[g]  = pay_q[g+1];
    end

    issue_queue_entry #(.PAYLOAD_WIDTH(PAYLOAD_WIDTH)) u_entry (
      .clk               (clk),
      .rst               (rst),
      .flush             (flush),
      .op                (slot_op[g]),
      .neighbour         (nb_slot[g]),
      .neighbour_payload (nb_pay[g]),
      .load_slot         (new_slot),
      .load_payload      (payload_in),
      .cdb_en            (cdb_en),
      .cdb_rob_addr      (cdb_rob_addr),
      .cdb_data          (cdb_data),
      .slot              (slot_q[g]),
      .payload           (pay_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || flush) count_q <= '0;
    else              count_q <= count_q + CW'(do_insert) - CW'(do_issue);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid     <= 1'b0;
      issue_rob_addr  <= '0;
      issue_opgen     <= '0;
      issue_operand_1 <= '0;
      issue_operand_2 <= '0;
      issue_pc        <= '0;
      issue_payload   <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (!stall_next_stage) begin
      issue_valid <= do_issue;
      if (do_issue) begin
        issue_rob_addr  <= slot_q[sel].rob_addr;
        issue_opgen     <= slot_q[sel].opgen;
        issue_operand_1 <= slot_q[sel].data_1;
        issue_operand_2 <= slot_q[sel].data_2;
        issue_pc        <= slot_q[sel].pc;
        issue_payload   <= pay_q[sel];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int N  = 4;
  localparam int PW = 64;

  logic                      clk = 1'b0;
  logic                      rst, flush, stall_next_stage, can_issue_in;
  logic [ROB_ADDR_WIDTH-1:0] rob_addr_in;
  logic [OPGEN_WIDTH-1:0]    opgen_in;
  logic                      operand_is_ref_1_in, operand_is_ref_2_in;
  logic [DATA_WIDTH-1:0]     operand_data_1_in, operand_data_2_in;
  logic [ADDR_WIDTH-1:0]     pc_in;
  logic [PW-1:0]             payload_in;
  logic                      full;
  logic                      cdb_en;
  logic [ROB_ADDR_WIDTH-1:0] cdb_rob_addr;
  logic [DATA_WIDTH-1:0]     cdb_data;
  logic                      issue_valid;
  logic [ROB_ADDR_WIDTH-1:0] issue_rob_addr;
  logic [OPGEN_WIDTH-1:0]    issue_opgen;
  logic [DATA_WIDTH-1:0]     issue_operand_1, issue_operand_2;
  logic [ADDR_WIDTH-1:0]     issue_pc;
  logic [PW-1:0]             issue_payload;

  issue_queue #(.ENTRY_NUM(N), .PAYLOAD_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_next_stage(stall_next_stage),
    .can_issue_in(can_issue_in), .rob_addr_in(rob_addr_in), .opgen_in(opgen_in),
    .operand_is_ref_1_in(operand_is_ref_1_in), .operand_is_ref_2_in(operand_is_ref_2_in),
    .operand_data_1_in(operand_data_1_in), .operand_data_2_in(operand_data_2_in),
    .pc_in(pc_in), .payload_in(payload_in), .full(full),
    .cdb_en(cdb_en), .cdb_rob_addr(cdb_rob_addr), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_rob_addr(issue_rob_addr), .issue_opgen(issue_opgen),
    .issue_operand_1(issue_operand_1), .issue_operand_2(issue_operand_2),
    .issue_pc(issue_pc), .issue_payload(issue_payload)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [ROB_ADDR_WIDTH-1:0] rob;
    logic [OPGEN_WIDTH-1:0]    opgen;
    logic                      r1, r2;
    logic [DATA_WIDTH-1:0]     d1, d2;
    logic [ADDR_WIDTH-1:0]     pc;
    logic [PW-1:0]             pay;
  } m_entry_t;

  m_entry_t exp_q[$];        // queued instructions, oldest first
  m_entry_t exp_out;         // expected contents of the issue register
  logic     exp_valid  = 1'b0;
  logic     exp_full   = 1'b0;
  bit       model_live = 1'b0;

  always @(posedge clk) begin
    bit       full_pre;
    int       pick;
    m_entry_t e;
    full_pre = (exp_q.size() == N);
    if (rst || flush) begin
      exp_q.delete();
      exp_valid = 1'b0;
      if (rst) exp_out = '{default: '0};
    end else begin
      if (!stall_next_stage) begin
        pick = -1;
        foreach (exp_q[i])
          if (pick < 0 && !exp_q[i].r1 && !exp_q[i].r2) pick = i;
        if (pick >= 0) begin
          exp_out   = exp_q[pick];
          exp_valid = 1'b1;
          exp_q.delete(pick);
        end else begin
          exp_valid = 1'b0;
        end
      end
      if (cdb_en) begin
        foreach (exp_q[i]) begin
          if (exp_q[i].r1 && exp_q[i].d1[ROB_ADDR_WIDTH-1:0] == cdb_rob_addr) begin
            exp_q[i].r1 = 1'b0; exp_q[i].d1 = cdb_data;
          end
          if (exp_q[i].r2 && exp_q[i].d2[ROB_ADDR_WIDTH-1:0] == cdb_rob_addr) begin
            exp_q[i].r2 = 1'b0; exp_q[i].d2 = cdb_data;
          end
        end
      end
      if (can_issue_in && !full_pre) begin
        e.rob = rob_addr_in; e.opgen = opgen_in; e.pc = pc_in; e.pay = payload_in;
        e.r1  = operand_is_ref_1_in; e.d1 = operand_data_1_in;
        e.r2  = operand_is_ref_2_in; e.d2 = operand_data_2_in;
        if (cdb_en && e.r1 && e.d1[ROB_ADDR_WIDTH-1:0] == cdb_rob_addr) begin
          e.r1 = 1'b0; e.d1 = cdb_data;
        end
        if (cdb_en && e.r2 && e.d2[ROB_ADDR_WIDTH-1:0] == cdb_rob_addr) begin
          e.r2 = 1'b0; e.d2 = cdb_data;
        end
        exp_q.push_back(e);
      end
    end
    exp_full   = (exp_q.size() == N);
    model_live = 1'b1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("full", 64'(full), 64'(exp_full));
      check("issue_valid", 64'(issue_valid), 64'(exp_valid));
      if (exp_valid) begin
        check("issue_rob_addr",  64'(issue_rob_addr),  64'(exp_out.rob));
        check("issue_opgen",     64'(issue_opgen),     64'(exp_out.opgen));
        check("issue_operand_1", 64'(issue_operand_1), 64'(exp_out.d1));
        check("issue_operand_2", 64'(issue_operand_2), 64'(exp_out.d2));
        check("issue_pc",        64'(issue_pc),        64'(exp_out.pc));
        check("issue_payload",   issue_payload,        exp_out.pay);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst = 1'b0; flush = 1'b0; stall_next_stage = 1'b0; can_issue_in = 1'b0;
    rob_addr_in = '0; opgen_in = '0; operand_is_ref_1_in = 1'b0; operand_is_ref_2_in = 1'b0;
    operand_data_1_in = '0; operand_data_2_in = '0; pc_in = '0; payload_in = '0;
    cdb_en = 1'b0; cdb_rob_addr = '0; cdb_data = '0;
  endtask

  task automatic drive_insert(input int rob, input bit r1, input int d1, input bit r2, input int d2);
    can_issue_in        = 1'b1;
    rob_addr_in         = ROB_ADDR_WIDTH'(rob);
    opgen_in            = OPGEN_WIDTH'(rob + 8'h40);
    operand_is_ref_1_in = r1;
    operand_is_ref_2_in = r2;
    operand_data_1_in   = DATA_WIDTH'(d1);
    operand_data_2_in   = DATA_WIDTH'(d2);
    pc_in               = ADDR_WIDTH'(32'h1000 + rob * 4);
    payload_in          = {32'hCAFE0000, 32'(rob)};
  endtask

  task automatic drive_cdb(input int tag, input int data);
    cdb_en       = 1'b1;
    cdb_rob_addr = ROB_ADDR_WIDTH'(tag);
    cdb_data     = DATA_WIDTH'(data);
  endtask

  task automatic drive_random();
    rst              = ($urandom_range(0, 199) == 0);
    flush            = ($urandom_range(0, 49) == 0);
    stall_next_stage = ($urandom_range(0, 3) == 0);
    can_issue_in     = ($urandom_range(0, 9) < 6);
    rob_addr_in      = ROB_ADDR_WIDTH'($urandom);
    opgen_in         = OPGEN_WIDTH'($urandom);
    operand_is_ref_1_in = 1'($urandom_range(0, 1));
    operand_is_ref_2_in = 1'($urandom_range(0, 1));
    operand_data_1_in   = $urandom;
    operand_data_2_in   = $urandom;
    if (operand_is_ref_1_in) operand_data_1_in[ROB_ADDR_WIDTH-1:0] = ROB_ADDR_WIDTH'($urandom_range(0, 3));
    if (operand_is_ref_2_in) operand_data_2_in[ROB_ADDR_WIDTH-1:0] = ROB_ADDR_WIDTH'($urandom_range(0, 3));
    pc_in        = $urandom;
    payload_in   = {$urandom, $urandom};
    cdb_en       = ($urandom_range(0, 9) < 4);
    cdb_rob_addr = ROB_ADDR_WIDTH'($urandom_range(0, 3));
    cdb_data     = $urandom;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    tick(); tick();
    // Reset state
    check("rst_full", 64'(full), 64'd0);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_rob_addr", 64'(issue_rob_addr), 64'd0);
    check("rst_issue_operand_1", 64'(issue_operand_1), 64'd0);
    check("rst_issue_operand_2", 64'(issue_operand_2), 64'd0);
    check("rst_issue_payload", issue_payload, 64'd0);
    drive_idle();

    // Ready instruction issues two edges after it is presented
    drive_insert(3, 0, 5, 0, 7);
    tick();
    drive_idle();
    check("t2_not_yet", 64'(issue_valid), 64'd0);
    tick();
    check("t2_valid", 64'(issue_valid), 64'd1);
    check("t2_rob", 64'(issue_rob_addr), 64'd3);
    check("t2_op1", 64'(issue_operand_1), 64'd5);
    check("t2_op2", 64'(issue_operand_2), 64'd7);

    // Wake-up from the CDB
    drive_insert(1, 1, 5, 0, 9);
    tick();
    drive_idle();
    tick();
    drive_cdb(5, 32'hDEAD);
    tick();
    drive_idle();
    check("t3_waiting", 64'(issue_valid), 64'd0);
    tick();
    check("t3_valid", 64'(issue_valid), 64'd1);
    check("t3_rob", 64'(issue_rob_addr), 64'd1);
    check("t3_op1", 64'(issue_operand_1), 64'hDEAD);

    // Insert bypass: operand resolved by the same-cycle broadcast
    drive_insert(4, 0, 11, 1, 2);
    drive_cdb(2, 32'h1234);
    tick();
    drive_idle();
    tick();
    check("t4_valid", 64'(issue_valid), 64'd1);
    check("t4_rob", 64'(issue_rob_addr), 64'd4);
    check("t4_op2", 64'(issue_operand_2), 64'h1234);

    // Fill with unready entries, drop a 5th, release tag 9 in age order
    drive_insert(10, 1, 9, 0, 1); tick();
    drive_insert(11, 1, 9, 0, 2); tick();
    drive_insert(12, 1, 8, 0, 3); tick();
    drive_insert(13, 1, 9, 0, 4); tick();
    check("t5_full", 64'(full), 64'd1);
    drive_insert(14, 0, 1, 0, 1); tick();
    check("t5_still_full", 64'(full), 64'd1);
    check("t5_dropped", 64'(issue_valid), 64'd0);
    drive_idle();
    drive_cdb(9, 32'h99);
    tick();
    drive_idle();
    tick();
    check("t5_first_rob", 64'(issue_rob_addr), 64'd10);
    check("t5_first_valid", 64'(issue_valid), 64'd1);
    check("t5_full_drop", 64'(full), 64'd0);
    tick();
    check("t5_second_rob", 64'(issue_rob_addr), 64'd11);
    tick();
    check("t5_third_rob", 64'(issue_rob_addr), 64'd13);
    check("t5_third_op1", 64'(issue_operand_1), 64'h99);
    tick();
    check("t5_tag8_waits", 64'(issue_valid), 64'd0);

    // Stall holds the output; flush clears everything
    drive_insert(6, 0, 60, 0, 61); tick();
    drive_idle(); tick();
    check("t6_valid", 64'(issue_valid), 64'd1);
    stall_next_stage = 1'b1;
    drive_insert(7, 0, 70, 0, 71);
    for (int i = 0; i < 3; i++) begin
      tick();
      can_issue_in = 1'b0;
      check("t6_hold_valid", 64'(issue_valid), 64'd1);
      check("t6_hold_rob", 64'(issue_rob_addr), 64'd6);
    end
    drive_idle();
    flush = 1'b1;
    tick();
    check("t6_flush_valid", 64'(issue_valid), 64'd0);
    check("t6_flush_full", 64'(full), 64'd0);
    drive_idle();
    drive_cdb(8, 32'h88);
    tick();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_after_flush", 64'(issue_valid), 64'd0);
    end

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end
    drive_idle();
    for (int i = 0; i < 20; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
